// File: rtl/gray_monitor.sv
// gray_monitor: decodes the upstream 3-bit Gray counter, counts 7->0 wraps
// and latches a fault on illegal steps or wrap/overflow disagreement.
//
// Ports:
//   Clk       clock, rising edge
//   Reset     synchronous active-high reset, highest priority
//   Gray_in   Gray code from the upstream counter
//   Ovf_in    upstream sticky overflow flag
//   Clear     synchronous fault/statistics clear
//   Bin       registered binary decode of the last Gray_in sample
//   Wraps     saturating count of legal 7->0 wraps
//   Step_err  one-cycle pulse after an illegal transition
//   Fault     high while latched in the fault state
//   Ovf_err   sticky: a wrap was seen while Ovf_in was low
//
// Build option: define GRAY_REVERSE_EN to accept down-steps; a 0->7
// reverse wrap then decrements Wraps (saturating at 0).

module gray_monitor #(
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        Gray_in,
  input  logic              Ovf_in,
  input  logic              Clear,
  output logic [2:0]        Bin,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Step_err,
  output logic              Fault,
  output logic              Ovf_err
);

  typedef enum logic [1:0] {
    S_INIT,
    S_TRACK,
    S_FAULT
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t            r_state;
  state_t            w_state_nx;
  logic [2:0]        r_bin;
  logic [2:0]        r_prev;
  logic [2:0]        w_prev_nx;
  logic [WRAP_W-1:0] r_wraps;
  logic [WRAP_W-1:0] w_wraps_nx;
  logic              r_step_err;
  logic              w_step_err_nx;
  logic              r_ovf_err;
  logic              w_ovf_err_nx;

  logic [2:0]        w_nb;
  logic              w_hold;
  logic              w_fwd;
  logic              w_wrap;
  logic              w_rev;
  logic              w_rwrap;

  assign w_nb = {Gray_in[2], ^Gray_in[2:1], ^Gray_in};

  // Transition classes are mutually exclusive by construction.
  assign w_hold = (w_nb == r_prev);
  assign w_fwd  = (r_prev != 3'd7) &&
                  (w_nb == r_prev + 3'd1);
  assign w_wrap = (r_prev == 3'd7) &&
                  (w_nb == 3'd0);

`ifdef GRAY_REVERSE_EN
  assign w_rev   = (r_prev != 3'd0) &&
                   (w_nb == r_prev - 3'd1);
  assign w_rwrap = (r_prev == 3'd0) &&
                   (w_nb == 3'd7);
`else
  assign w_rev   = 1'b0;
  assign w_rwrap = 1'b0;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_prev_nx     = r_prev;
    w_wraps_nx    = r_wraps;
    w_ovf_err_nx  = r_ovf_err;
    w_step_err_nx = 1'b0;
    if (Clear) begin
      // Clear overrides any event on this edge.
      w_state_nx   = S_INIT;
      w_prev_nx    = w_nb;
      w_wraps_nx   = '0;
      w_ovf_err_nx = 1'b0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          w_prev_nx  = w_nb;
          w_state_nx = S_TRACK;
        end
        S_TRACK: begin
          w_prev_nx = w_nb;
          unique case (1'b1)
            w_hold: ;
            w_fwd:  ;
            w_wrap: begin
              if (r_wraps != WRAP_MAX)
                w_wraps_nx = r_wraps + 1'b1;
              if (!Ovf_in) begin
                w_ovf_err_nx = 1'b1;
                w_state_nx   = S_FAULT;
              end
            end
            w_rev:  ;
            w_rwrap: begin
              if (r_wraps != '0)
                w_wraps_nx = r_wraps - 1'b1;
            end
            default: begin
              w_step_err_nx = 1'b1;
              w_state_nx    = S_FAULT;
            end
          endcase
        end
        S_FAULT: ;
        default: w_state_nx = S_INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_INIT;
      r_bin      <= '0;
      r_prev     <= '0;
      r_wraps    <= '0;
      r_step_err <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bin      <= w_nb;
      r_prev     <= w_prev_nx;
      r_wraps    <= w_wraps_nx;
      r_step_err <= w_step_err_nx;
      r_ovf_err  <= w_ovf_err_nx;
    end
  end

  assign Bin      = r_bin;
  assign Wraps    = r_wraps;
  assign Step_err = r_step_err;
  assign Ovf_err  = r_ovf_err;
  assign Fault    = (r_state == S_FAULT);

endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: directed and random stimulus for gray_monitor,
// checked against a behavioural model of the monitor rules.

module tb_gray_monitor;

  localparam int WRAP_W = 4;
  localparam int WMAX   = (1 << WRAP_W) - 1;

`ifdef GRAY_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [2:0]        Gray_in = '0;
  logic              Ovf_in = 1'b0;
  logic              Clear = 1'b0;
  logic [2:0]        Bin;
  logic [WRAP_W-1:0] Wraps;
  logic              Step_err;
  logic              Fault;
  logic              Ovf_err;

  int n_cmp = 0;
  int n_bad = 0;

  int m_bin;
  int m_wraps;
  int m_prev;
  bit m_se;
  bit m_oe;
  bit m_tracking;
  bit m_faulted;

  gray_monitor #(.WRAP_W(WRAP_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Gray_in  (Gray_in),
    .Ovf_in   (Ovf_in),
    .Clear    (Clear),
    .Bin      (Bin),
    .Wraps    (Wraps),
    .Step_err (Step_err),
    .Fault    (Fault),
    .Ovf_err  (Ovf_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc(input int b);
    logic [2:0] v;
    v = b[2:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int dec(input logic [2:0] g);
    for (int i = 0; i < 8; i++)
      if (enc(i) == g) return i;
    return 0;
  endfunction

  task automatic model(
    input int b, input bit ovf,
    input bit clr, input bit rst
  );
    int d;
    if (rst) begin
      m_bin = 0; m_wraps = 0; m_prev = 0;
      m_se = 0; m_oe = 0;
      m_tracking = 0; m_faulted = 0;
      return;
    end
    m_bin = b;
    m_se  = 0;
    if (clr) begin
      m_wraps = 0; m_oe = 0;
      m_tracking = 0; m_faulted = 0;
    end else if (m_faulted) begin
    end else if (!m_tracking) begin
      m_prev = b;
      m_tracking = 1;
    end else begin
      d = (b - m_prev + 8) % 8;
      if (d == 0) begin
      end else if (d == 1) begin
        if (m_prev == 7) begin
          if (m_wraps < WMAX) m_wraps++;
          if (!ovf) begin
            m_oe = 1;
            m_faulted = 1;
          end
        end
        m_prev = b;
      end else if (REV && d == 7) begin
        if (m_prev == 0 && m_wraps > 0)
          m_wraps--;
        m_prev = b;
      end else begin
        m_se = 1;
        m_faulted = 1;
      end
    end
  endtask

  task automatic step(
    input int b, input bit ovf,
    input bit clr, input bit rst
  );
    @(negedge Clk);
    Gray_in = enc(b);
    Ovf_in  = ovf;
    Clear   = clr;
    Reset   = rst;
    @(posedge Clk);
    model(dec(enc(b)), ovf, clr, rst);
    #1;
    chk("bin", 32'(Bin), 32'(m_bin));
    chk("wraps", 32'(Wraps), 32'(m_wraps));
    chk("step_err", 32'(Step_err), 32'(m_se));
    chk("fault", 32'(Fault), 32'(m_faulted));
    chk("ovf_err", 32'(Ovf_err), 32'(m_oe));
  endtask

  task automatic lap(input bit ovf_wrap);
    for (int i = 1; i < 8; i++) step(i, 1'b0, 1'b0, 1'b0);
    step(0, ovf_wrap, 1'b0, 1'b0);
  endtask

  initial begin
    int src;
    int r;
    bit ovf;
    bit clr;
    bit rst;

    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    chk("rst_wraps", 32'(Wraps), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);

    // Full forward lap, then a legal wrap.
    step(0, 1'b0, 1'b0, 1'b0);
    lap(1'b1);
    chk("wrap1", 32'(Wraps), 32'd1);
    chk("wrap1_flt", 32'(Fault), 32'd0);
    for (int k = 0; k < 16; k++) lap(1'b1);
    chk("wrap_sat", 32'(Wraps), 32'(WMAX));

    // Illegal jump 1 -> 4.
    step(0, 1'b1, 1'b1, 1'b0);
    step(1, 1'b0, 1'b0, 1'b0);
    step(4, 1'b0, 1'b0, 1'b0);
    chk("jump_pulse", 32'(Step_err), 32'd1);
    chk("jump_flt", 32'(Fault), 32'd1);
    step(5, 1'b0, 1'b0, 1'b0);
    chk("pulse_end", 32'(Step_err), 32'd0);
    step(6, 1'b0, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    chk("flt_frozen", 32'(Wraps), 32'd0);

    // Clear together with an illegal jump.
    step(3, 1'b0, 1'b1, 1'b0);
    chk("clr_flt", 32'(Fault), 32'd0);
    chk("clr_se", 32'(Step_err), 32'd0);
    step(6, 1'b0, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0, 1'b0);
    chk("baseline", 32'(Fault), 32'd0);

    // Wrap with Ovf_in low.
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);
    lap(1'b0);
    chk("oe_set", 32'(Ovf_err), 32'd1);
    chk("oe_flt", 32'(Fault), 32'd1);
    chk("oe_wraps", 32'(Wraps), 32'd1);

    // Down-stepping through a reverse wrap.
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0);
    lap(1'b1);
    step(1, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(7, 1'b1, 1'b0, 1'b0);
    chk("rev_flt", 32'(Fault), REV ? 32'd0 : 32'd1);
    chk("rev_wraps", 32'(Wraps), REV ? 32'd0 : 32'd1);

    // Random traffic.
    src = 0;
    step(0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      src = (src + 1) % 8;
      else if (r < 72) src = src;
      else if (r < 80) src = (src + 7) % 8;
      else             src = $urandom_range(0, 7);
      ovf = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0) ||
            (m_faulted && $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(src, ovf, clr, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
